key_expansion_seq: RTL and testbench
====================================

KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10, 44 words).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new expansion; sampled on rising clk.
REQ-005 key  input  128 [0:127]  cipher key; bit 0 is the MSB of byte 0.
REQ-006 words  output  1408 [0:1407]  expanded schedule; round key i at words[128*i +: 128], i=0..10.
REQ-007 busy  output  1  high while expansion is in progress.
REQ-008 done  output  1  high when all 11 round keys in words are valid; held until the next accepted start or reset.

Function
REQ-009 The block SHALL have states IDLE and RUN, with a 4-bit round counter rnd.
REQ-010 In IDLE, start=1 SHALL be accepted on that edge:
- key is written to words[0:127]
- rnd<=1, busy<=1, done<=0
- the state moves to RUN.
REQ-011 key SHALL be sampled only on the accepting edge; later changes to key SHALL NOT affect the result.
REQ-012 In RUN, each edge SHALL write exactly one round key, rnd, into words[128*rnd +: 128], computed from round key rnd-1 already held in words.
REQ-013 Word arithmetic, with w = 32-bit words of the schedule (w[0] = key[0:31]):
- w[4r] = w[4r-4] ^ SubWord(RotWord(w[4r-1])) ^ {Rcon[r], 24'h0}
- w[4r+j] = w[4r+j-4] ^ w[4r+j-1], j=1..3.
REQ-014 RotWord SHALL rotate bytes left by one ([a0 a1 a2 a3] -> [a1 a2 a3 a0]); SubWord SHALL apply the forward AES S-box to each byte.
REQ-015 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 The edge that writes round key 10 SHALL also set busy<=0, done<=1 and return the state to IDLE.
REQ-017 Latency: done SHALL be high exactly 10 clk cycles after the start-accepting edge; that is 11 edges total, including the accepting one.
REQ-018 start SHALL be ignored while busy=1; the expansion continues unaffected.
REQ-019 start=1 in IDLE with done=1 SHALL restart the expansion: done drops on the same edge.
REQ-020 Back-to-back use SHALL be supported: start held high continuously SHALL begin a new expansion on the edge after each completion, giving a period of 11 cycles.
REQ-021 During RUN, round keys above rnd-1 SHALL retain their previous values; consumers SHALL use words only while done=1.
REQ-022 busy and done SHALL never be high simultaneously.
REQ-023 words SHALL change only on start acceptance, on RUN writes, or on reset.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force:
- state=IDLE, rnd=0
- busy=0, done=0
- words = all zeros.
REQ-025 Reset asserted mid-RUN SHALL abort the expansion; no partial result is kept and done stays 0.
REQ-026 After rst_n deasserts, the block SHALL accept start on the first rising edge at which rst_n=1.

Verification
REQ-027 key = 2b7e151628aed2a6abf7158809cf4f3c, start pulsed for 1 cycle. Required response:
- busy high for 10 cycles, then done=1
- round key 1 = a0fafe1788542cb123a339392a6c7605
- round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-028 key = 000102030405060708090a0b0c0d0e0f. Required response: round key 10 = 13111d7fe3944a17f307a78b4d2b30c5 and round key 0 = the key itself.
REQ-029 Start a run with the key of REQ-027. On cycle 4, pulse start with key = all zeros. Required response: the second start is ignored and the final words match REQ-027 exactly.
REQ-030 Assert rst_n=0 asynchronously at cycle 5 of a run. Required response: busy, done and words are 0 immediately. After release, a fresh start gives the REQ-028 result in 10 cycles.
REQ-031 Hold start high across two runs: REQ-027 key, then REQ-028 key applied after the first done. Required response:
- done pulses low for exactly 10 cycles between the two results
- the second result matches REQ-028.
REQ-032 Change key during RUN, after the accepting edge. Required response: output is unchanged from the value produced by the sampled key.

Source files
------------

// File: rtl/key_expansion_seq.sv
// AES-128 key schedule, one round key per clock into an 11-entry (1408-bit) register file.
// start is taken only in IDLE; done rises 10 edges after acceptance and holds until the next start.
module key_expansion_seq (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [0:127]  key,
  output logic [0:1407] words,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Forward S-box; byte b lives at bits [8*b +: 8] counting from the left.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [0:1407]  words_q;

  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [0:127]   wr_dat;
  logic [0:127]   prev_rk;
  logic [0:127]   next_rk;
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    n0, n1, n2, n3;

  // Round key rnd-1 is the only source for round key rnd.
  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < 10; i++) begin
      if (rnd_q == 4'(i + 1)) prev_rk = words_q[128*i +: 128];
    end
  end

  assign w0 = prev_rk[0:31];
  assign w1 = prev_rk[32:63];
  assign w2 = prev_rk[64:95];
  assign w3 = prev_rk[96:127];

  assign n0 = w0 ^ sub_rot(w3) ^ {rcon(rnd_q), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wr_en   = 1'b0;
    wr_idx  = rnd_q;
    wr_dat  = next_rk;
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_dat  = key;
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        wr_en = 1'b1;
        if (rnd_q == 4'd10) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else begin
      for (int i = 0; i < 11; i++) begin
        if (wr_en && wr_idx == 4'(i)) words_q[128*i +: 128] <= wr_dat;
      end
    end
  end

  assign words = words_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: GF(2^8)-derived reference schedule, per-cycle compare, FIPS-197 vectors.
module tb_key_expansion_seq;

  localparam logic [0:127] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [0:127]  key = '0;
  logic [0:1407] words;
  logic          busy, done;

  always #5 clk = ~clk;

  key_expansion_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .words (words),
    .busy  (busy),
    .done  (done)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:1407] expand(input logic [0:127] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  // Reference: on acceptance the whole schedule is known; round r becomes visible after r more edges.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_cnt = 0;
  logic [0:1407] m_prev = '0;
  logic [0:1407] m_new = '0;
  logic [0:1407] exp_words;

  always_comb begin
    exp_words = m_prev;
    for (int r = 0; r < 11; r++) begin
      if (r <= m_cnt) exp_words[128*r +: 128] = m_new[128*r +: 128];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_prev <= '0;
      m_new  <= '0;
    end else if (!m_busy && start) begin
      m_prev <= exp_words;
      m_new  <= expand(key);
      m_cnt  <= 0;
      m_busy <= 1'b1;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 9) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end
  end

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rk(input string nm, input logic [0:127] act, input logic [0:127] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_words(input string nm, input logic [0:1407] act, input logic [0:1407] exp);
    bit reported = 1'b0;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int r = 0; r < 11; r++) begin
        if (!reported && act[128*r +: 128] !== exp[128*r +: 128]) begin
          reported = 1'b1;
          $display("FAIL %s: round %0d got %h want %h at %0t", nm, r,
                   act[128*r +: 128], exp[128*r +: 128], $time);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk_bit("busy", busy, m_busy);
    chk_bit("done", done, m_done);
    chk_bit("busy_done_excl", busy & done, 1'b0);
    chk_words("words", words, exp_words);
  endtask

  // c0 = negedges already seen after the one following the accepting edge.
  task automatic wait_done(input string nm, input int c0);
    int c = c0;
    while (!done && c < 30) begin
      tick();
      c++;
    end
    chk_int(nm, c, 10);
  endtask

  initial begin
    logic [0:1407] t;
    int lows;

    build_sbox();
    chk_int("sbox_00", int'(sb[8'h00]), 'h63);
    chk_int("sbox_53", int'(sb[8'h53]), 'hed);
    t = expand(K1);
    chk_rk("model_k1_r1", t[128 +: 128], K1_R1);
    chk_rk("model_k1_r10", t[1280 +: 128], K1_R10);
    t = expand(K2);
    chk_rk("model_k2_r10", t[1280 +: 128], K2_R10);

    repeat (3) tick();

    // Start on the very first edge after release, pulsed for one cycle.
    rst_n = 1'b1;
    start = 1'b1;
    key   = K1;
    tick();
    start = 1'b0;
    wait_done("k1_latency", 0);
    chk_rk("dut_k1_r0", words[0 +: 128], K1);
    chk_rk("dut_k1_r1", words[128 +: 128], K1_R1);
    chk_rk("dut_k1_r10", words[1280 +: 128], K1_R10);

    // Restart from done=1; key wiggled after acceptance.
    start = 1'b1;
    key   = K2;
    tick();
    start = 1'b0;
    key   = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    repeat (3) tick();
    key   = ~K2;
    wait_done("k2_latency", 3);
    chk_rk("dut_k2_r0", words[0 +: 128], K2);
    chk_rk("dut_k2_r10", words[1280 +: 128], K2_R10);

    // A start pulse mid-run must be ignored.
    start = 1'b1;
    key   = K1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    key   = '0;
    tick();
    start = 1'b0;
    wait_done("ignored_start_latency", 4);
    chk_rk("ignored_start_r1", words[128 +: 128], K1_R1);
    chk_rk("ignored_start_r10", words[1280 +: 128], K1_R10);

    // Asynchronous abort mid-run.
    start = 1'b1;
    key   = K1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_bit("arst_busy", busy, 1'b0);
    chk_bit("arst_done", done, 1'b0);
    chk_words("arst_words", words, '0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    key   = K2;
    tick();
    start = 1'b0;
    wait_done("post_reset_latency", 0);
    chk_rk("post_reset_r10", words[1280 +: 128], K2_R10);

    // start held high across two runs.
    start = 1'b1;
    key   = K1;
    tick();
    wait_done("b2b_first_latency", 0);
    chk_rk("b2b_first_r10", words[1280 +: 128], K1_R10);
    key  = K2;
    lows = 0;
    tick();
    while (!done && lows < 30) begin
      lows++;
      tick();
    end
    start = 1'b0;
    chk_int("b2b_done_low", lows, 10);
    chk_rk("b2b_second_r0", words[0 +: 128], K2);
    chk_rk("b2b_second_r10", words[1280 +: 128], K2_R10);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
